sipo_deframer: RTL and testbench

- Receive-side counterpart to the team's cyclic/parallel-load shift registers.
- Accepts a serial bit stream, MSB first, qualified by a valid strobe and a start-of-word marker.
- Assembles WIDTH-bit words and presents each on a parallel output register with a valid/ready handshake.
- Flags framing errors and overruns; sits between a serial link and parallel consumer logic.

---
 rtl/sipo_deframer_pkg.sv | 21 ++
 rtl/sipo_core.sv | 60 ++++++
 rtl/sipo_deframer.sv | 105 ++++++++++
 tb/tb_sipo_deframer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deframer_pkg.sv
// ---------------------------------------------------------------------------
// sipo_deframer_pkg : shared state encoding and counter sizing for the deframer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sipo_deframer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter must hold values 0..WIDTH
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_core.sv
// ---------------------------------------------------------------------------
// sipo_core : shift register and bit counter; exposes the post-shift word
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sipo_core
  import sipo_deframer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_load_first,
  input  logic                            i_shift_en,
  input  logic                            i_sin,
  output logic [WIDTH-1:0]                o_next_word,
  output logic [cnt_width(WIDTH)-1:0]     o_count
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_base;

  // A first bit starts from a clean register so stale bits never leak
  assign w_base = i_load_first ? '0 : r_sreg;

  generate
    if (MSB_FIRST) begin : g_msb_first
      logic w_unused_top;
      assign w_unused_top = w_base[WIDTH-1];
      assign o_next_word  = {w_base[WIDTH-2:0], i_sin};
    end else begin : g_lsb_first
      logic w_unused_bottom;
      assign w_unused_bottom = w_base[0];
      assign o_next_word     = {i_sin, w_base[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg  <= '0;
      r_count <= '0;
    end else if (i_load_first) begin
      r_sreg  <= o_next_word;
      r_count <= CW'(1);
    end else if (i_shift_en) begin
      r_sreg  <= o_next_word;
      r_count <= (r_count == CW'(WIDTH - 1)) ? '0 : r_count + CW'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/sipo_deframer.sv
// ---------------------------------------------------------------------------
// sipo_deframer : serial-to-parallel deframer with valid/ready output and
//                 sticky framing/overrun flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_load_first;
  logic             w_shift_en;
  logic             w_complete;
  logic             w_accept;
  logic [WIDTH-1:0] w_next_word;
  logic [CW-1:0]    w_count;

  assign w_load_first = sin_valid & sof;
  assign w_shift_en   = sin_valid & ~sof & (r_state == ST_SHIFT);
  assign w_complete   = w_shift_en & (w_count == CW'(WIDTH - 1));
  // Output slot is free if empty or being drained on this same edge
  assign w_accept     = ~r_dout_valid | out_ready;

  sipo_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .i_load_first (w_load_first),
    .i_shift_en   (w_shift_en),
    .i_sin        (sin),
    .o_next_word  (w_next_word),
    .o_count      (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load_first) begin
        r_state <= ST_SHIFT;
      end else if (w_complete) begin
        r_state <= ST_IDLE;
      end

      if (w_complete && w_accept) begin
        r_dout       <= w_next_word;
        r_dout_valid <= 1'b1;
      end else if (out_ready) begin
        r_dout_valid <= 1'b0;
      end

      if (w_load_first && (r_state == ST_SHIFT)) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end

      if (w_complete && !w_accept) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == ST_SHIFT);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deframer.sv
// ---------------------------------------------------------------------------
// tb_sipo_deframer : three deframer variants driven in parallel and compared
//                    every beat against a bit-list reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deframer;

  logic clk = 1'b0;
  logic reset;
  logic sin, sin_valid, sof, out_ready, clr_err;

  always #5 clk = ~clk;

  logic [3:0] d0_dout;
  logic [3:0] d1_dout;
  logic [1:0] d2_dout;
  logic [2:0] a_valid, a_busy, a_ferr, a_ovr;
  logic [7:0] a_dout [3];

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .out_ready(out_ready), .clr_err(clr_err), .dout(d0_dout),
    .dout_valid(a_valid[0]), .busy(a_busy[0]), .frame_err(a_ferr[0]), .overrun(a_ovr[0]));

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .out_ready(out_ready), .clr_err(clr_err), .dout(d1_dout),
    .dout_valid(a_valid[1]), .busy(a_busy[1]), .frame_err(a_ferr[1]), .overrun(a_ovr[1]));

  sipo_deframer #(.WIDTH(2), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .out_ready(out_ready), .clr_err(clr_err), .dout(d2_dout),
    .dout_valid(a_valid[2]), .busy(a_busy[2]), .frame_err(a_ferr[2]), .overrun(a_ovr[2]));

  assign a_dout[0] = {4'b0, d0_dout};
  assign a_dout[1] = {4'b0, d1_dout};
  assign a_dout[2] = {6'b0, d2_dout};

  localparam int WD [3] = '{4, 4, 2};
  localparam int MF [3] = '{1, 0, 1};

  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference: collected bits of the word in progress, plus output state
  int         plen    [3];
  logic       pbits   [3][8];
  logic [7:0] m_dout  [3];
  logic       m_valid [3];
  logic       m_ferr  [3];
  logic       m_ovr   [3];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      plen[k]    = 0;
      m_dout[k]  = '0;
      m_valid[k] = 1'b0;
      m_ferr[k]  = 1'b0;
      m_ovr[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic v, input logic s, input logic f,
                            input logic r, input logic c);
    for (int k = 0; k < 3; k++) begin
      logic       complete = 1'b0;
      logic       fset     = 1'b0;
      logic       oset     = 1'b0;
      logic [7:0] word     = '0;
      if (v) begin
        if (f) begin
          if (plen[k] > 0) fset = 1'b1;
          pbits[k][0] = s;
          plen[k] = 1;
        end else if (plen[k] > 0) begin
          pbits[k][plen[k]] = s;
          plen[k]++;
          if (plen[k] == WD[k]) begin
            complete = 1'b1;
            for (int i = 0; i < WD[k]; i++) begin
              if (MF[k] == 1) word[WD[k]-1-i] = pbits[k][i];
              else            word[i]         = pbits[k][i];
            end
            plen[k] = 0;
          end
        end
      end
      if (complete && (!m_valid[k] || r)) begin
        m_dout[k]  = word;
        m_valid[k] = 1'b1;
      end else begin
        if (complete) oset = 1'b1;
        if (m_valid[k] && r) m_valid[k] = 1'b0;
      end
      if (fset)      m_ferr[k] = 1'b1;
      else if (c)    m_ferr[k] = 1'b0;
      if (oset)      m_ovr[k]  = 1'b1;
      else if (c)    m_ovr[k]  = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_dout", k),  a_dout[k],         m_dout[k]);
      check($sformatf("d%0d_valid", k), {7'b0, a_valid[k]}, {7'b0, m_valid[k]});
      check($sformatf("d%0d_busy", k),  {7'b0, a_busy[k]},  {7'b0, logic'(plen[k] > 0)});
      check($sformatf("d%0d_ferr", k),  {7'b0, a_ferr[k]},  {7'b0, m_ferr[k]});
      check($sformatf("d%0d_ovr", k),   {7'b0, a_ovr[k]},   {7'b0, m_ovr[k]});
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic f,
                      input logic r, input logic c);
    sin_valid = v; sin = s; sof = f; out_ready = r; clr_err = c;
    model_step(v, s, f, r, c);
    @(posedge clk); #1;
    compare_all();
  endtask

  // Bits go out w[3] first; r_mid applies to the first three beats
  task automatic send_word(input logic [3:0] w, input logic r_mid, input logic r_last);
    for (int i = 3; i >= 0; i--) begin
      beat(1'b1, w[i], logic'(i == 3), (i == 0) ? r_last : r_mid, 1'b0);
    end
  endtask

  task automatic gap();
    beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic check_reset_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_d%0d_dout", tag, k), a_dout[k], 8'h00);
      check($sformatf("%s_d%0d_flags", tag, k),
            {4'b0, a_valid[k], a_busy[k], a_ferr[k], a_ovr[k]}, 8'h00);
    end
  endtask

  initial begin
    reset = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero("rst0");
    reset = 1'b1;

    // 1/2: 1,0,1,1 -> 1011 (MSB first), 1101 (LSB first)
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_dout_msb", a_dout[0], 8'b1011);
    check("t1_valid", {7'b0, a_valid[0]}, 8'd1);
    check("t2_dout_lsb", a_dout[1], 8'b1101);
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_valid_drop", {7'b0, a_valid[0]}, 8'd0);

    // 3: partial 1,1 cut by a new sof with 0,1,1,0
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(4'b0110, 1'b1, 1'b1);
    check("t3_dout", a_dout[0], 8'h06);
    check("t3_ferr", {7'b0, a_ferr[0]}, 8'd1);

    // 4: hold 4'hA, drop 4'h5, then clear
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(4'hA, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    check("t4_dout_held", a_dout[0], 8'h0A);
    check("t4_ovr", {7'b0, a_ovr[0]}, 8'd1);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_ovr_clr", {7'b0, a_ovr[0]}, 8'd0);
    check("t4_dout_after_clr", a_dout[0], 8'h0A);

    // 5: 4'h3 completes on the edge that drains held 4'hC
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(4'hC, 1'b0, 1'b0);
    check("t5_held", a_dout[0], 8'h0C);
    send_word(4'h3, 1'b0, 1'b1);
    check("t5_dout", a_dout[0], 8'h03);
    check("t5_valid", {7'b0, a_valid[0]}, 8'd1);
    check("t5_ovr", {7'b0, a_ovr[0]}, 8'd0);

    // 6: reset mid-word, then 4'h9 with idle gaps
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_zero("rst1");
    @(posedge clk); #1;
    check_reset_zero("rst1_hold");
    reset = 1'b1;
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    gap();
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    gap();
    gap();
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    gap();
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_dout", a_dout[0], 8'h09);
    check("t6_valid", {7'b0, a_valid[0]}, 8'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      beat(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
